// File: rtl/mem_pkg.sv
// Shared definitions for the MEM stage: memory-op and exception codes, FSM
// states, the latched instruction bundle and the alignment/op-class helpers.
package mem_pkg;

  localparam int TIMEOUT_DEF = 16;
  localparam int NUM_LANES   = 4;

  typedef enum logic [3:0] {
    MOP_NONE = 4'd0,
    MOP_LW   = 4'd1,
    MOP_LH   = 4'd2,
    MOP_LHU  = 4'd3,
    MOP_LB   = 4'd4,
    MOP_LBU  = 4'd5,
    MOP_SW   = 4'd6,
    MOP_SH   = 4'd7,
    MOP_SB   = 4'd8
  } mop_e;

  typedef enum logic [1:0] {
    EXC_NONE = 2'd0,
    EXC_ADEL = 2'd1,
    EXC_ADES = 2'd2,
    EXC_BUS  = 2'd3
  } exc_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
    logic [31:0] res;
    logic [4:0]  rwa;
    logic [3:0]  mop;
    logic        tn;
  } fields_t;

  function automatic logic is_load(input logic [3:0] m);
    return m inside {MOP_LW, MOP_LH, MOP_LHU, MOP_LB, MOP_LBU};
  endfunction

  function automatic logic is_store(input logic [3:0] m);
    return m inside {MOP_SW, MOP_SH, MOP_SB};
  endfunction

  function automatic logic misaligned(input logic [3:0] m, input logic [1:0] a);
    logic r;
    case (m)
      MOP_LW, MOP_SW:          r = (a != 2'b00);
      MOP_LH, MOP_LHU, MOP_SH: r = a[0];
      default:                 r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Picks the addressed byte/half lane out of a little-endian read word and
// sign- or zero-extends it according to the load op.
module load_extend
  import mem_pkg::*;
(
  input  logic [3:0]  i_mop,
  input  logic [1:0]  i_addr,
  input  logic [31:0] i_raw,
  output logic [31:0] o_ext
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_raw[{i_addr, 3'b000} +: 8];
  assign w_half = i_addr[1] ? i_raw[31:16] : i_raw[15:0];

  always_comb begin
    o_ext = i_raw;
    case (i_mop)
      MOP_LH:  o_ext = {{16{w_half[15]}}, w_half};
      MOP_LHU: o_ext = {16'h0000, w_half};
      MOP_LB:  o_ext = {{24{w_byte[7]}}, w_byte};
      MOP_LBU: o_ext = {24'h000000, w_byte};
      default: o_ext = i_raw;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// MIPS MEM stage: single-outstanding data-bus master with byte-lane alignment,
// load extension, address/bus error reporting and upstream stall.
module mem_access
  import mem_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] pc,
  input  logic [31:0] ins,
  input  logic [4:0]  rwa,
  input  logic [31:0] res,
  input  logic [31:0] wd,
  input  logic [3:0]  mop,
  input  logic        tn,
  output logic        stall,
  output logic        validM,
  output logic [31:0] pcM,
  output logic [31:0] insM,
  output logic [4:0]  rwaM,
  output logic [31:0] resM,
  output logic [1:0]  dalM,
  output logic        tnM,
  output logic [31:0] rwdM,
  output logic [1:0]  excM,
  output logic        dreq,
  output logic        dwe,
  output logic [31:0] daddr,
  output logic [3:0]  dbe,
  output logic [31:0] dwdata,
  input  logic        dready,
  input  logic [31:0] drdata
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_e                             r_state, w_next;
  fields_t                            r_f;
  logic [31:0]                        r_daddr, r_dwdata, r_rwd;
  logic [3:0]                         r_dbe;
  logic                               r_dwe, r_buserr;
  logic [CW-1:0]                      r_cnt;

  logic                               w_ld, w_st, w_mis, w_accept, w_tmo;
  logic [NUM_LANES-1:0]               w_dbe;
  logic [NUM_LANES-1:0][7:0]          w_lane;
  logic [31:0]                        w_ext;

  assign w_ld     = is_load(mop);
  assign w_st     = is_store(mop);
  assign w_mis    = misaligned(mop, res[1:0]);
  assign w_accept = (r_state == S_IDLE) && in_valid && (w_ld || w_st) && !w_mis;
  assign w_tmo    = (r_cnt == CW'(TIMEOUT - 1));

  // Store lane steering; loads and SW enable all lanes with data in place.
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    assign w_dbe[l]  = (mop == MOP_SB) ? (res[1:0] == 2'(l)) :
                       (mop == MOP_SH) ? (res[1] == 1'(l / 2)) : 1'b1;
    assign w_lane[l] = (mop == MOP_SB) ? wd[7:0] :
                       (mop == MOP_SH) ? wd[8*(l%2) +: 8] : wd[8*l +: 8];
  end

  load_extend u_ext (
    .i_mop  (r_f.mop),
    .i_addr (r_f.res[1:0]),
    .i_raw  (drdata),
    .o_ext  (w_ext)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    stall  = 1'b0;
    validM = 1'b0;
    dreq   = 1'b0;
    dwe    = 1'b0;
    dbe    = 4'b0000;
    pcM    = r_f.pc;
    insM   = r_f.ins;
    rwaM   = r_f.rwa;
    resM   = r_f.res;
    dalM   = r_f.res[1:0];
    tnM    = r_f.tn;
    rwdM   = r_rwd;
    excM   = EXC_NONE;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next = S_BUSY;
        // Reset gating keeps stall/validM at 0 while reset is held.
        stall  = reset && w_accept;
        validM = reset && in_valid && !w_accept;
        pcM    = pc;
        insM   = ins;
        resM   = res;
        dalM   = res[1:0];
        tnM    = tn;
        rwaM   = w_mis ? 5'd0 : rwa;
        rwdM   = w_mis ? 32'd0 : res;
        excM   = w_mis ? (w_ld ? EXC_ADEL : EXC_ADES) : EXC_NONE;
      end
      S_BUSY: begin
        if (dready || w_tmo) w_next = S_DONE;
        stall = 1'b1;
        dreq  = 1'b1;
        dwe   = r_dwe;
        dbe   = r_dbe;
      end
      S_DONE: begin
        w_next = S_IDLE;
        validM = 1'b1;
        if (r_buserr) begin
          excM = EXC_BUS;
          rwaM = 5'd0;
          rwdM = 32'd0;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_f      <= '0;
      r_daddr  <= '0;
      r_dwdata <= '0;
      r_rwd    <= '0;
      r_dbe    <= '0;
      r_dwe    <= 1'b0;
      r_buserr <= 1'b0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_f      <= '{pc: pc, ins: ins, res: res, rwa: rwa, mop: mop, tn: tn};
          r_daddr  <= {res[31:2], 2'b00};
          r_dbe    <= w_dbe;
          r_dwdata <= w_lane;
          r_dwe    <= w_st;
          r_rwd    <= res;
          r_buserr <= 1'b0;
          r_cnt    <= '0;
        end
        S_BUSY: begin
          r_cnt <= r_cnt + CW'(1);
          // A completion on the last allowed cycle still beats the timeout.
          if (dready) begin
            if (is_load(r_f.mop)) r_rwd <= w_ext;
          end else if (w_tmo) begin
            r_buserr <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign daddr  = r_daddr;
  assign dwdata = r_dwdata;

endmodule

// File: doc/mem_access.md
# mem_access

Memory-access stage of the five-stage MIPS pipeline, between the EX/MEM register and the MEM_WB register. Decodes the memory op carried with the instruction, drives a single-outstanding request/ready data bus with byte-lane alignment, extends load data, and presents a complete MEM-stage bundle (`pcM`, `insM`, `rwaM`, `resM`, `dalM`, `tnM`, `rwdM`) to MEM_WB. Stalls upstream while a bus transaction is in flight and reports address and bus errors.

## Interface
- `TIMEOUT`, 16: BUSY cycles without `dready` before a bus error is declared (≥2).
- `clk` in 1: pipeline clock.
- `reset` in 1: asynchronous, active-low.
- `in_valid` in 1: EX/MEM holds a real instruction.
- `pc`, `ins` in 32 each: instruction address and word.
- `rwa` in 5: destination register.
- `res` in 32: ALU result / effective address.
- `wd` in 32: store data (rt).
- `mop` in 4: memory op code.
- `tn` in 1: result-ready flag, passed through.
- `stall` out 1: freeze PC, IF/ID, ID/EX, EX/MEM.
- `validM` out 1: bundle valid; MEM_WB loads a bubble when 0.
- `pcM`, `insM`, `resM`, `rwdM` out 32 each: pass-through fields plus write-back data.
- `rwaM` out 5: destination; 0 suppresses write-back.
- `dalM` out 2: effective address bits [1:0].
- `tnM` out 1: pass-through flag.
- `excM` out 2: 0 none, 1 AdEL, 2 AdES, 3 bus error.
- `dreq`, `dwe` out 1 each: request, write enable.
- `daddr` out 32: word-aligned address, {res[31:2],2'b00}.
- `dbe` out 4: byte enables.
- `dwdata` out 32: lane-replicated store data.
- `dready` in 1: transaction complete this cycle.
- `drdata` in 32: read data, valid with `dready`.

## Operation
- `mop`: 0 NONE, 1 LW, 2 LH, 3 LHU, 4 LB, 5 LBU, 6 SW, 7 SH, 8 SB; 9–15 treated as NONE.
- Alignment: LW/SW need res[1:0]=0; LH/LHU/SH need res[0]=0. A misaligned op issues no request and completes in the same cycle. It drives `validM=1`, `rwaM=0`, and `excM` = AdEL for loads or AdES for stores.
- Store lanes:
  - SB: `dbe`=1<<res[1:0], `dwdata`={4{wd[7:0]}}.
  - SH: `dbe`=res[1]?1100:0011, `dwdata`={2{wd[15:0]}}.
  - SW: `dbe`=1111, `dwdata`=wd.
- Loads: `dbe`=1111. Lane selected by res[1:0]. LB/LH sign-extend; LBU/LHU zero-extend.
- `rwdM`:
  - extended load data for loads.
  - `res` for NONE and stores.
  - 0 on any exception.
- FSM states IDLE, BUSY, DONE:
  - IDLE, no valid aligned memory op: outputs pass through combinationally, `validM=in_valid`, `stall=0`.
  - IDLE, valid aligned op: `stall=1`, `validM=0`. At the clock edge, latch all fields plus `daddr`/`dbe`/`dwdata`/`dwe`, clear the timeout counter, go to BUSY.
  - BUSY: `dreq=1` with latched, stable fields; `stall=1`; `validM=0`.
    - `dready` → latch extended `drdata` (loads), go to DONE.
    - Counter reaches TIMEOUT-1 with no `dready` → set bus-error flag, go to DONE.
  - DONE: outputs come from latches; `validM=1`; `stall=0`. Bus error forces `excM=3`, `rwaM=0`, `rwdM=0`. Next edge returns to IDLE. EX/MEM advances on that same edge.
- `dreq` is 0 outside BUSY. A `dready` seen outside BUSY is ignored.
- Reset asserted mid-transaction: immediately IDLE, `dreq=0`, latches cleared. No completion is reported.

## Timing
- Reset values: state IDLE, all latches 0, `dreq`/`dwe`=0, `dbe`=0, `stall`=0. `validM` follows `in_valid` (0 while reset is held low).
- Non-memory and misaligned ops: 0 added cycles; one instruction per clock.
- Memory op with `dready` in the first BUSY cycle: 3 cycles (IDLE accept, BUSY, DONE). Each extra wait cycle adds 1.
- Timeout: `excM=3` appears in DONE, TIMEOUT+2 cycles after accept.
- `stall` depends combinationally on `in_valid`/`mop`/`res` in IDLE only. In all other states it is purely registered.

## Structure
- Package `mem_pkg`: `mop` codes, `excM` codes, FSM state enum, `TIMEOUT` default.
- Sub-module `load_extend` (combinational): takes `mop`, addr[1:0], raw word; returns the 32-bit extended value.
- Top level holds the FSM, timeout counter, field latches and lane generation.

## Test plan
- ADD (`mop`=0), `res`=0x1234 → same cycle: `validM=1`, `rwdM`=0x1234, `stall=0`, `dreq=0`.
- LB, `res`=0x103, `drdata`=0x80FF_FF12, `dready` in first BUSY cycle → `stall` high for 2 cycles; in DONE `rwdM`=0xFFFF_FF80, `dalM`=3.
- SH, `res`=0x202, `wd`=0xABCD → `dbe`=1100, `dwdata`=0xABCD_ABCD, `daddr`=0x200, `dwe=1`. Fields are held stable across 3 wait cycles.
- LW, `res`=0x101 → no `dreq`; same cycle `excM=1`, `rwaM=0`, `validM=1`.
- LW, `TIMEOUT`=4, `dready` held low → `dreq` high 4 cycles, then DONE with `excM=3`, `rwdM=0`.
- Reset pulled low during BUSY → `dreq` drops within the same cycle (asynchronous). After release: state IDLE, no `validM` for the aborted op.
